// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 multiplier / 32/32 divider feeding the HI/LO registers.
// Works on operand magnitudes one bit per clock, then fixes up the signs in a
// final cycle. hi_out/lo_out only change when a result is delivered.
//
// state | meaning
// IDLE  | waiting for start; operands and signs latched on acceptance
// MUL   | 32 shift-add iterations on magnitudes
// DIV   | 32 restoring-division iterations on magnitudes
// FIX   | sign correction, result write, done pulse
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;     // MUL: {partial product, multiplier}; DIV: {rem, quo}
    logic [31:0] opnd_q, opnd_d;   // |multiplicand| or |divisor|, unsigned
    logic        op_q, op_d;
    logic        neg_q, neg_d;     // sign(a) ^ sign(b)
    logic        sa_q, sa_d;       // sign(a), gives remainder sign
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dzo_q, dzo_d;

    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [31:0] rem_sh;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // Magnitudes, iteration steps and sign fix-up values.
    always_comb begin
        abs_a    = a_in[31] ? (32'd0 - a_in) : a_in;
        abs_b    = b_in[31] ? (32'd0 - b_in) : b_in;
        // Carry out of the add becomes the new MSB as the accumulator shifts right.
        mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
        mul_next = {mul_sum, acc_q[31:1]};
        // rem < divisor <= 2^31, so the shifted remainder always fits in 32 bits.
        rem_sh   = {acc_q[62:32], acc_q[31]};
        div_diff = {1'b0, rem_sh} - {1'b0, opnd_q};
        div_next = div_diff[32] ? {rem_sh, acc_q[30:0], 1'b0}
                                : {div_diff[31:0], acc_q[30:0], 1'b1};
        prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
        quo_fix  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_fix  = sa_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    neg_d = a_in[31] ^ b_in[31];
                    sa_d  = a_in[31];
                    cnt_d = 6'd0;
                    dz_d  = 1'b0;
                    if (!op) begin
                        opnd_d  = abs_a;
                        acc_d   = {32'd0, abs_b};
                        state_d = MUL;
                    end else if (b_in == 32'd0) begin
                        dz_d    = 1'b1;
                        state_d = FIX;
                    end else begin
                        opnd_d  = abs_b;
                        acc_d   = {32'd0, abs_a};
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = FIX;
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                if (!dz_q) begin
                    if (!op_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == FIX);
        dzo_d  = (state_q == FIX) && dz_q;
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            op_q    <= 1'b0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dzo_q;

endmodule
